// File: rtl/ha_sched_pkg.sv
// Shared types and the round-robin pick function for the half-adder scheduler.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
// Contents: state_e (scheduler FSM states), tag_t (in-flight tag), rr_pick().
package ha_sched_pkg;

    // Upper bounds on requester count / ID width. Vectors handled by the
    // shared function are sized to these and narrowed at the call sites.
    localparam int MAX_NREQ = 8;
    localparam int MAX_IDW  = 3;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DRAINED = 2'd3
    } state_e;

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    // One-hot grant to the first valid requester found searching upward from
    // ptr+1, wrapping modulo nreq (so non-power-of-2 counts wrap correctly).
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [MAX_IDW-1:0]  ptr,
        input int unsigned         nreq
    );
        logic [MAX_NREQ-1:0] gnt;
        logic [31:0]         idx;
        logic                found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
            if ((k <= nreq) && !found) begin
                idx = (32'(ptr) + k) % nreq;
                if (valid[idx[MAX_IDW-1:0]]) begin
                    gnt[idx[MAX_IDW-1:0]] = 1'b1;
                    found                 = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ha_rr_arb.sv
// Round-robin arbiter: combinational one-hot pick plus registered last-grant pointer.
// Latency: grant is combinational from i_vld; pointer updates on the grant edge.
// Backpressure: i_en=0 suppresses every grant and freezes the pointer.
// Ports: clk, rst (sync, active-high), i_en, i_vld[NREQ] in; o_gnt[NREQ], o_gnt_vld, o_gnt_id out.
module ha_rr_arb
    import ha_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_vld,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_gnt_vld,
    output logic [IDW-1:0]  o_gnt_id
);

    logic [IDW-1:0]      r_ptr;
    logic [MAX_NREQ-1:0] w_vld_ext;
    logic [MAX_NREQ-1:0] w_pick;
    logic [MAX_NREQ-1:0] w_gnt_full;
    logic [IDW-1:0]      w_id;

    assign w_vld_ext  = MAX_NREQ'(i_vld);
    assign w_pick     = rr_pick(w_vld_ext, MAX_IDW'(r_ptr), NREQ);
    assign w_gnt_full = i_en ? w_pick : '0;
    assign o_gnt      = NREQ'(w_gnt_full);
    assign o_gnt_vld  = |w_gnt_full;
    assign o_gnt_id   = w_id;

    // One-hot to index; stays 0 when nothing is granted.
    always_comb begin
        w_id = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (w_gnt_full[i]) begin
                w_id = IDW'(i);
            end
        end
    end

    // Starting at NREQ-1 makes requester 0 the first choice after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IDW'(NREQ - 1);
        end else if (o_gnt_vld) begin
            r_ptr <= w_id;
        end
    end

endmodule

// File: rtl/ha_sched.sv
// Shares one pipelined half_adder among NREQ requesters: INIT sequencing, RR arbitration, tag pipeline, drain.
// Latency: operands reach ha_a/ha_b in the grant cycle; the tagged result appears LAT cycles later.
// Backpressure: requesters wait on req_ready; responses cannot be stalled; drain_req blocks new grants.
// Ports: clk, rst, req_valid/req_a/req_b[NREQ], drain_req, ha_sum, ha_carry in;
//        req_ready[NREQ], drain_done, ha_rstn, ha_a, ha_b, rsp_valid, rsp_id, rsp_sum, rsp_carry out.
module ha_sched
    import ha_sched_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int LAT      = 1,
    parameter  int INIT_CYC = 2,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    input  logic            drain_req,
    output logic            drain_done,
    output logic            ha_rstn,
    output logic            ha_a,
    output logic            ha_b,
    input  logic            ha_sum,
    input  logic            ha_carry,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_sum,
    output logic            rsp_carry
);

    localparam int CW = $clog2(INIT_CYC + 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_init_cnt;
    tag_t            r_tag [LAT];

    logic            w_grant_en;
    logic            w_upstream_empty;
    logic [NREQ-1:0] w_gnt;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_id;

    ha_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_grant_en),
        .i_vld     (req_valid),
        .o_gnt     (w_gnt),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_id  (w_gnt_id)
    );

    // The last stage is the one presenting its result this cycle, so the
    // pipeline is empty after this edge when every earlier stage is a bubble
    // (nothing enters while draining). With LAT=1 this is trivially true.
    always_comb begin
        w_upstream_empty = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (r_tag[i].vld) begin
                w_upstream_empty = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == CW'(INIT_CYC - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A drain request blocks the grant in the very cycle it is seen.
                if (drain_req) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_grant_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_upstream_empty) begin
                    w_state_nxt = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
        if (rst) begin
            w_grant_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + CW'(1);
            end
        end
    end

    // Tag pipeline mirrors the adder latency; bubbles carry vld=0, id=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_gnt_vld, id: MAX_IDW'(w_gnt_id)};
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign req_ready  = w_gnt;
    assign ha_a       = |(w_gnt & req_a);
    assign ha_b       = |(w_gnt & req_b);
    // Outputs are forced idle while rst is asserted so in-flight tags never surface.
    assign ha_rstn    = !rst && (r_state != ST_INIT);
    assign drain_done = !rst && (r_state == ST_DRAINED);
    assign rsp_valid  = !rst && r_tag[LAT-1].vld;
    assign rsp_id     = rst ? '0 : IDW'(r_tag[LAT-1].id);
    assign rsp_sum    = ha_sum;
    assign rsp_carry  = ha_carry;

endmodule

// File: tb/tb_ha_sched.sv
// Bench for ha_sched: two configurations (A: NREQ=4 LAT=1 INIT_CYC=2, B: NREQ=3 LAT=3 INIT_CYC=3)
// driven side by side with directed and random stimulus, each checked every cycle against a
// transaction-level model (grant search, a time-stamped queue of expected responses, drain phases).
module tb_ha_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [1:0] drn;
    logic [7:0] rv [2];
    logic [7:0] ra [2];
    logic [7:0] rb [2];

    // DUT A signals
    logic [3:0] a_rdy;
    logic       a_done, a_rstn, a_ha_a, a_ha_b, a_hs, a_hc, a_rv, a_sum, a_car;
    logic [1:0] a_rid;
    // DUT B signals
    logic [2:0] b_rdy;
    logic       b_done, b_rstn, b_ha_a, b_ha_b, b_hs, b_hc, b_rv, b_sum, b_car;
    logic [1:0] b_rid;

    ha_sched #(.NREQ(4), .LAT(1), .INIT_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst_v[0]),
        .req_valid(rv[0][3:0]), .req_a(ra[0][3:0]), .req_b(rb[0][3:0]), .req_ready(a_rdy),
        .drain_req(drn[0]), .drain_done(a_done),
        .ha_rstn(a_rstn), .ha_a(a_ha_a), .ha_b(a_ha_b), .ha_sum(a_hs), .ha_carry(a_hc),
        .rsp_valid(a_rv), .rsp_id(a_rid), .rsp_sum(a_sum), .rsp_carry(a_car)
    );

    ha_sched #(.NREQ(3), .LAT(3), .INIT_CYC(3)) u_dut_b (
        .clk(clk), .rst(rst_v[1]),
        .req_valid(rv[1][2:0]), .req_a(ra[1][2:0]), .req_b(rb[1][2:0]), .req_ready(b_rdy),
        .drain_req(drn[1]), .drain_done(b_done),
        .ha_rstn(b_rstn), .ha_a(b_ha_a), .ha_b(b_ha_b), .ha_sum(b_hs), .ha_carry(b_hc),
        .rsp_valid(b_rv), .rsp_id(b_rid), .rsp_sum(b_sum), .rsp_carry(b_car)
    );

    // Environment half adders: {carry, sum}, registered through LAT stages.
    logic [1:0] hp_a [1];
    logic [1:0] hp_b [3];
    always @(posedge clk) begin
        hp_a[0] <= {a_ha_a & a_ha_b, a_ha_a ^ a_ha_b};
        hp_b[0] <= {b_ha_a & b_ha_b, b_ha_a ^ b_ha_b};
        hp_b[1] <= hp_b[0];
        hp_b[2] <= hp_b[1];
    end
    assign a_hs = hp_a[0][0];
    assign a_hc = hp_a[0][1];
    assign b_hs = hp_b[2][0];
    assign b_hc = hp_b[2][1];

    // ---------------- reference model ----------------
    typedef struct {
        int d;
        int due;
        int id;
        bit a;
        bit b;
    } ent_t;

    int   nq [2] = '{4, 3};
    int   lt [2] = '{1, 3};
    int   ic [2] = '{2, 3};
    int   phase [2];     // 0 init, 1 run, 2 drain, 3 drained
    int   initleft [2];
    int   ptr [2];
    ent_t pend [$];
    int   cyc;
    int   npass;
    int   nchk;
    int   nfail;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int d);
        logic [7:0] o_rdy, o_id;
        logic       o_rstn, o_a, o_b, o_rv, o_sum, o_car, o_done;
        string      p;
        int         g, hit, idx;
        bit         any;
        logic [7:0] e_rdy;
        if (d == 0) begin
            p = "A";
            o_rdy = 8'(a_rdy); o_id = 8'(a_rid); o_rstn = a_rstn; o_a = a_ha_a; o_b = a_ha_b;
            o_rv = a_rv; o_sum = a_sum; o_car = a_car; o_done = a_done;
        end else begin
            p = "B";
            o_rdy = 8'(b_rdy); o_id = 8'(b_rid); o_rstn = b_rstn; o_a = b_ha_a; o_b = b_ha_b;
            o_rv = b_rv; o_sum = b_sum; o_car = b_car; o_done = b_done;
        end

        if (rst_v[d]) begin
            chk({p, ".rst_ready"}, o_rdy, 8'd0);
            chk({p, ".rst_ha_rstn"}, 8'(o_rstn), 8'd0);
            chk({p, ".rst_ha_ab"}, 8'({o_a, o_b}), 8'd0);
            chk({p, ".rst_rsp_valid"}, 8'(o_rv), 8'd0);
            chk({p, ".rst_rsp_id"}, o_id, 8'd0);
            chk({p, ".rst_drain_done"}, 8'(o_done), 8'd0);
            phase[d]    = 0;
            initleft[d] = ic[d];
            ptr[d]      = nq[d] - 1;
            for (int j = pend.size() - 1; j >= 0; j--) begin
                if (pend[j].d == d) pend.delete(j);
            end
            return;
        end

        // Grant: first valid requester after the last one granted.
        g = -1;
        if (phase[d] == 1 && !drn[d]) begin
            for (int k = 1; k <= nq[d]; k++) begin
                idx = (ptr[d] + k) % nq[d];
                if (g < 0 && rv[d][idx]) g = idx;
            end
        end
        e_rdy = (g >= 0) ? (8'd1 << g) : 8'd0;
        chk({p, ".req_ready"}, o_rdy, e_rdy);
        chk({p, ".ha_rstn"}, 8'(o_rstn), 8'(phase[d] != 0));
        chk({p, ".ha_a"}, 8'(o_a), (g >= 0) ? 8'(ra[d][g]) : 8'd0);
        chk({p, ".ha_b"}, 8'(o_b), (g >= 0) ? 8'(rb[d][g]) : 8'd0);
        chk({p, ".drain_done"}, 8'(o_done), 8'(phase[d] == 3));

        hit = -1;
        foreach (pend[j]) begin
            if (pend[j].d == d && pend[j].due == cyc) hit = j;
        end
        chk({p, ".rsp_valid"}, 8'(o_rv), 8'(hit >= 0));
        if (hit >= 0) begin
            chk({p, ".rsp_id"}, o_id, 8'(pend[hit].id));
            chk({p, ".rsp_sum"}, 8'(o_sum), 8'(pend[hit].a ^ pend[hit].b));
            chk({p, ".rsp_carry"}, 8'(o_car), 8'(pend[hit].a & pend[hit].b));
            pend.delete(hit);
        end

        if (g >= 0) begin
            ptr[d] = g;
            pend.push_back('{d: d, due: cyc + lt[d], id: g, a: ra[d][g], b: rb[d][g]});
        end

        any = 1'b0;
        foreach (pend[j]) begin
            if (pend[j].d == d) any = 1'b1;
        end
        case (phase[d])
            0: begin
                initleft[d]--;
                if (initleft[d] == 0) phase[d] = 1;
            end
            1: if (drn[d]) phase[d] = 2;
            2: if (!any) phase[d] = 3;
            default: if (!drn[d]) phase[d] = 1;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input int d, input bit r, input bit dr,
                         input logic [7:0] v, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] m;
        m = 8'((1 << nq[d]) - 1);
        rst_v[d] = r;
        drn[d]   = dr;
        rv[d]    = v & m;
        ra[d]    = a & m;
        rb[d]    = b & m;
    endtask

    initial begin
        cyc = 0; npass = 0; nchk = 0; nfail = 0;
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; initleft[d] = ic[d]; ptr[d] = nq[d] - 1;
        end

        // Reset held 3 cycles, then INIT with every requester asking.
        setin(0, 1, 0, 8'hff, 8'hff, 8'hff);
        setin(1, 1, 0, 8'hff, 8'hff, 8'hff);
        repeat (3) step();
        setin(0, 0, 0, 8'hff, 8'hff, 8'hff);
        setin(1, 0, 0, 8'hff, 8'hff, 8'hff);
        repeat (3) step();

        // Single request: requester 2 (A: a=1,b=1), requester 1 (B: a=1,b=0).
        setin(0, 1, 0, 8'h00, 8'h00, 8'h00);
        setin(1, 1, 0, 8'h00, 8'h00, 8'h00);
        step();
        setin(0, 0, 0, 8'h00, 8'h00, 8'h00);
        setin(1, 0, 0, 8'h00, 8'h00, 8'h00);
        repeat (3) step();
        setin(0, 0, 0, 8'b0100, 8'b0100, 8'b0100);
        setin(1, 0, 0, 8'b010, 8'b010, 8'b000);
        step();
        setin(0, 0, 0, 8'h00, 8'h00, 8'h00);
        setin(1, 0, 0, 8'h00, 8'h00, 8'h00);
        repeat (4) step();

        // Round robin: A all four (a=id[0], b=id[1]); B 3'b101 wraps 2->0.
        setin(0, 0, 0, 8'b1111, 8'b1010, 8'b1100);
        setin(1, 0, 0, 8'b101, 8'b001, 8'b100);
        repeat (8) step();

        // Back-to-back issues then drain; release and resume.
        setin(0, 0, 0, 8'hff, 8'h5a, 8'h33);
        setin(1, 0, 0, 8'hff, 8'h06, 8'h03);
        repeat (3) step();
        setin(0, 0, 1, 8'hff, 8'h5a, 8'h33);
        setin(1, 0, 1, 8'hff, 8'h06, 8'h03);
        repeat (7) step();
        setin(0, 0, 0, 8'hff, 8'h5a, 8'h33);
        setin(1, 0, 0, 8'hff, 8'h06, 8'h03);
        repeat (4) step();

        // Reset with results in flight; INIT repeats, first grant to requester 0.
        setin(0, 1, 0, 8'hff, 8'h0f, 8'h0f);
        setin(1, 1, 0, 8'hff, 8'h07, 8'h07);
        step();
        setin(0, 0, 0, 8'hff, 8'h0f, 8'h0f);
        setin(1, 0, 0, 8'hff, 8'h07, 8'h07);
        repeat (6) step();

        // Drain requested during INIT.
        setin(0, 1, 1, 8'hff, 8'h00, 8'hff);
        setin(1, 1, 1, 8'hff, 8'h00, 8'hff);
        step();
        setin(0, 0, 1, 8'hff, 8'h00, 8'hff);
        setin(1, 0, 1, 8'hff, 8'h00, 8'hff);
        repeat (8) step();
        setin(0, 0, 0, 8'hff, 8'h00, 8'hff);
        setin(1, 0, 0, 8'hff, 8'h00, 8'hff);
        repeat (3) step();

        // Random traffic with occasional drains and resets.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                bit r, dr;
                r  = ($urandom_range(63) == 0);
                dr = drn[d];
                if ($urandom_range(9) == 0) dr = ~dr;
                setin(d, r, dr, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            step();
        end

        setin(0, 0, 0, 8'h00, 8'h00, 8'h00);
        setin(1, 0, 0, 8'h00, 8'h00, 8'h00);
        repeat (8) step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ha_sched.md
Name: ha_sched

Overview:
- Round-robin scheduler sharing one registered half_adder instance between NREQ requesters.
- Owns the adder's reset sequencing (INIT), request arbitration, the in-flight tag pipeline and a drain/quiesce handshake.
- Returns each result to the originating requester, tagged by ID.
- Sits between requester logic and the half_adder datapath; the formal and sim benches drive it directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 1, cycles from issue edge to ha_sum/ha_carry valid (1..4).
- INIT_CYC, 2, cycles ha_rstn is held low after reset (>=1).
- IDW, $clog2(NREQ), ID width (derived, not overridable).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  NREQ  operand a, bit i for requester i.
- req_b  in  NREQ  operand b, bit i for requester i.
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready.
- drain_req  in  1  level; stop granting and empty the pipeline.
- drain_done  out  1  high while drained (state DRAINED).
- ha_rstn  out  1  active-low reset to half_adder.
- ha_a  out  1  operand to half_adder.
- ha_b  out  1  operand to half_adder.
- ha_sum  in  1  half_adder sum, valid LAT cycles after issue.
- ha_carry  in  1  half_adder carry, same timing as ha_sum.
- rsp_valid  out  1  result valid (no backpressure).
- rsp_id  out  IDW  requester index of result.
- rsp_sum  out  1  passes ha_sum.
- rsp_carry  out  1  passes ha_carry.

Behaviour:
- Reset (rst=1 at an edge): state=INIT, init counter=0, tag pipeline cleared, rr pointer=NREQ-1.
- Values during and after reset: req_ready=0, ha_rstn=0, ha_a=ha_b=0, rsp_valid=0, rsp_id=0, drain_done=0.
- FSM states: INIT, RUN, DRAIN, DRAINED.
- INIT: ha_rstn=0 for exactly INIT_CYC cycles after reset is released, then RUN. No grants in INIT.
- RUN: ha_rstn=1. Grant goes to the first i with req_valid[i], searching from ptr+1 modulo NREQ. req_ready is combinational from req_valid; at most one bit set per cycle.
- On grant: ha_a=req_a[i], ha_b=req_b[i] in the same cycle; ptr<=i; tag {1,i} enters the pipeline at the edge. No grant: ha_a=ha_b=0; bubble tag {0,x} enters.
- Tag pipeline: LAT stages. rsp_valid/rsp_id are the last stage, combinational. rsp_sum=ha_sum and rsp_carry=ha_carry unconditionally (consumers qualify with rsp_valid).
- Full throughput: one issue per cycle; LAT is fully pipelined.
- drain_req=1 in RUN: next state DRAIN, and no grant in that same cycle.
- DRAIN: no grants; pipeline keeps shifting; move to DRAINED when all tag stages are invalid.
- DRAINED: drain_done=1. When drain_req=0, return to RUN next cycle; grants resume that cycle, and drain_done=0 is registered with the state.
- drain_req during INIT: takes effect after INIT (INIT->RUN->DRAIN).
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 grant cycles.
- Requester drops valid without a grant: no effect, and ptr is unchanged.
- rst mid-operation: in-flight tags are discarded (no rsp_valid for them); ha_rstn goes low, full INIT repeats.
- Width rule: ptr wrap is modulo NREQ, correct for non-power-of-2 NREQ (e.g. 3: 2->0).

Decomposition:
- Package ha_sched_pkg: state enum (INIT, RUN, DRAIN, DRAINED); tag struct {logic vld; logic [IDW-1:0] id}; function rr_pick(valid, ptr) returning one-hot grant.
- Sub-module ha_rr_arb: combinational round-robin pick plus registered ptr, with NREQ as its only parameter.
- Tag pipeline and FSM stay in ha_sched.

Test Plan:
- Reset/INIT (INIT_CYC=2): rst=1 for 3 cycles, then 0 -> ha_rstn=0 for exactly 2 cycles, then 1; req_ready=0 throughout INIT even with req_valid=4'b1111.
- Single request (LAT=1): requester 2 issues a=1, b=1 -> ha_a=ha_b=1 in the grant cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_sum=0, rsp_carry=1.
- Round-robin: req_valid=4'b1111 held 8 cycles -> grant ids 0,1,2,3,0,1,2,3. Operands a=id[0], b=id[1] -> responses in the same order with the matching sum/carry.
- Drain with LAT=3: three back-to-back issues, then drain_req=1 -> no grant that cycle. The remaining responses arrive, drain_done=1 the cycle after the last, grants resume after drain_req=0.
- Reset mid-flight (LAT=3): two issues in flight, rst=1 -> no rsp_valid for them; INIT repeats; first post-INIT grant goes to the lowest valid id (ptr=NREQ-1).
- NREQ=3 wrap: req_valid=3'b101 held -> grants alternate 0,2,0,2; ptr wraps 2->0.
